bcd_field_accumulator: RTL and testbench

//   Sequential, parametrised BCD field decoder for the IRIG time-code path.
//   - Collects one time field (seconds, minutes, hours, days, ...) bit by bit as the frame decoder emits it.
//   - Converts the field to binary by multi-cycle Horner evaluation (acc = acc*10 + digit).
//   - Reports per-digit validity (digit > 9) and field range (value > MAX_VALUE).
//   - Sits between the IRIG symbol/frame FSM and the time-register block.

---
 rtl/bcd_field_accumulator.sv | 105 ++++++++++
 tb/tb_bcd_field_accumulator.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_field_accumulator.sv
// Bit-serial BCD time-field collector with multi-cycle Horner conversion to binary.
// Flags malformed digits and out-of-range field values alongside a one-cycle result strobe.
module bcd_field_accumulator #(
  parameter int NUM_DIGITS = 3,
  parameter int VALUE_W    = 10,
  parameter int MAX_VALUE  = 999
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               field_start,
  input  logic               bit_valid,
  input  logic               bit_value,
  input  logic [1:0]         bit_idx,
  input  logic [1:0]         digit_idx,
  input  logic               field_end,
  output logic               busy,
  output logic [VALUE_W-1:0] value_out,
  output logic               value_valid,
  output logic               digit_error,
  output logic               range_error
);

  typedef enum logic [1:0] {IDLE, COLLECT, CONVERT, FINISH} state_t;

  localparam logic [2:0]  DIGITS_U = 3'(NUM_DIGITS);
  localparam logic [1:0]  CNT_TOP  = 2'(NUM_DIGITS - 1);
  localparam logic [31:0] MAX_U    = 32'(MAX_VALUE);

  state_t             state;
  logic [3:0]         store [NUM_DIGITS];
  logic               idx_err;
  logic [1:0]         cnt;
  logic [VALUE_W-1:0] acc;
  logic               bad_digit;

  // acc*10 + digit, wrapping at VALUE_W bits
  function automatic logic [VALUE_W-1:0] horner_step(input logic [VALUE_W-1:0] a,
                                                     input logic [3:0] d);
    return (a << 3) + (a << 1) + VALUE_W'(d);
  endfunction

  function automatic logic over_range(input logic [VALUE_W-1:0] v);
    return 32'(v) > MAX_U;
  endfunction

  always_comb begin
    bad_digit = idx_err;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (store[i] > 4'd9) bad_digit = 1'b1;
    end
  end

  assign busy = (state == COLLECT) || (state == CONVERT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx_err     <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
      value_out   <= '0;
      value_valid <= 1'b0;
      digit_error <= 1'b0;
      range_error <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) store[i] <= 4'd0;
    end else begin
      value_valid <= 1'b0;
      // field_start restarts collection from any state, discarding an unfinished field
      if (field_start) begin
        state   <= COLLECT;
        idx_err <= 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) store[i] <= 4'd0;
      end else begin
        case (state)
          IDLE: ;
          COLLECT: begin
            if (bit_valid) begin
              if ({1'b0, digit_idx} < DIGITS_U) store[digit_idx][bit_idx] <= bit_value;
              else                               idx_err <= 1'b1;
            end
            if (field_end) begin
              state <= CONVERT;
              acc   <= '0;
              cnt   <= CNT_TOP;
            end
          end
          CONVERT: begin
            acc <= horner_step(acc, store[cnt]);
            cnt <= cnt - 2'd1;
            if (cnt == 2'd0) state <= FINISH;
          end
          FINISH: begin
            value_out   <= acc;
            digit_error <= bad_digit;
            range_error <= !bad_digit && over_range(acc);
            value_valid <= 1'b1;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_field_accumulator.sv
// Scoreboard bench for bcd_field_accumulator: two instances (MAX 366 and MAX 59) share stimulus;
// expected results are queued at field_end and checked by an independent monitor.
module tb_bcd_field_accumulator;

  localparam int unsigned LAT = 5;  // NUM_DIGITS + 2 edges from field_end sample to strobe

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       field_start = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_value = 1'b0;
  logic [1:0] bit_idx = 2'd0;
  logic [1:0] digit_idx = 2'd0;
  logic       field_end = 1'b0;

  logic       a_busy, a_value_valid, a_digit_error, a_range_error;
  logic       b_busy, b_value_valid, b_digit_error, b_range_error;
  logic [9:0] a_value_out, b_value_out;

  bcd_field_accumulator #(.NUM_DIGITS(3), .VALUE_W(10), .MAX_VALUE(366)) dut_a (
    .clk(clk), .rst_n(rst_n), .field_start(field_start), .bit_valid(bit_valid),
    .bit_value(bit_value), .bit_idx(bit_idx), .digit_idx(digit_idx), .field_end(field_end),
    .busy(a_busy), .value_out(a_value_out), .value_valid(a_value_valid),
    .digit_error(a_digit_error), .range_error(a_range_error)
  );

  bcd_field_accumulator #(.NUM_DIGITS(3), .VALUE_W(10), .MAX_VALUE(59)) dut_b (
    .clk(clk), .rst_n(rst_n), .field_start(field_start), .bit_valid(bit_valid),
    .bit_value(bit_value), .bit_idx(bit_idx), .digit_idx(digit_idx), .field_end(field_end),
    .busy(b_busy), .value_out(b_value_out), .value_valid(b_value_valid),
    .digit_error(b_digit_error), .range_error(b_range_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned value;
    bit          de;
    bit          ra;
    bit          rb;
    int unsigned cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every result strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (a_value_valid || b_value_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid: got value_valid a=%0d b=%0d value_out=%0d expected no output",
                 a_value_valid, b_value_valid, a_value_out);
      end else begin
        mon_e = sbq.pop_front();
        check("latency_cycle", cyc, mon_e.cyc);
        check("valid_a", 32'(a_value_valid), 32'd1);
        check("valid_b", 32'(b_value_valid), 32'd1);
        check("value_a", 32'(a_value_out), mon_e.value);
        check("value_b", 32'(b_value_out), mon_e.value);
        check("digit_error_a", 32'(a_digit_error), 32'(mon_e.de));
        check("digit_error_b", 32'(b_digit_error), 32'(mon_e.de));
        check("range_error_a", 32'(a_range_error), 32'(mon_e.ra));
        check("range_error_b", 32'(b_range_error), 32'(mon_e.rb));
      end
    end
  end

  task automatic drive(input bit fs, input bit bv, input bit bval,
                       input logic [1:0] bi, input logic [1:0] di, input bit fe);
    @(posedge clk);
    #1;
    field_start = fs;
    bit_valid   = bv;
    bit_value   = bval;
    bit_idx     = bi;
    digit_idx   = di;
    field_end   = fe;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
  endtask

  task automatic put_bit(input logic [1:0] di, input logic [1:0] bi, input bit v);
    drive(1'b0, 1'b1, v, bi, di, 1'b0);
  endtask

  task automatic put_digit(input logic [1:0] di, input logic [3:0] d);
    for (int b = 0; b < 4; b++)
      if (d[b]) put_bit(di, 2'(b), 1'b1);
  endtask

  task automatic put_field(input logic [11:0] bcd);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    put_digit(2'd2, bcd[11:8]);
    put_digit(2'd1, bcd[7:4]);
    put_digit(2'd0, bcd[3:0]);
  endtask

  // field_end (optionally with a last bit), queue the expected result, let conversion drain
  task automatic end_field(input bit bv, input bit bval, input logic [1:0] bi, input logic [1:0] di,
                           input int unsigned v, input bit de, input bit ra, input bit rb);
    exp_t t;
    drive(1'b0, bv, bval, bi, di, 1'b1);
    t.value = v;
    t.de    = de;
    t.ra    = ra;
    t.rb    = rb;
    t.cyc   = cyc + LAT;
    sbq.push_back(t);
    idle(8);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(a_busy), 32'd0);
    check("reset_value", 32'(a_value_out), 32'd0);
    check("reset_valid", 32'(a_value_valid), 32'd0);
    check("reset_flags", 32'({a_digit_error, a_range_error}), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // 245: in range for 366, out of range for 59
    put_field(12'h245);
    end_field(1'b0, 1'b0, 2'd0, 2'd0, 245, 1'b0, 1'b0, 1'b1);
    check("value_hold", 32'(a_value_out), 32'd245);

    // Reset mid-conversion clears outputs at once and suppresses the strobe
    put_field(12'h123);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
    idle(2);
    check("busy_convert", 32'(a_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(a_busy), 32'd0);
    check("async_rst_value", 32'(a_value_out), 32'd0);
    check("async_rst_valid", 32'(a_value_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    // field_end alone in IDLE does nothing
    drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
    idle(8);
    check("idle_field_end_busy", 32'(a_busy), 32'd0);

    // Invalid units digit 1010
    put_field(12'h00A);
    end_field(1'b0, 1'b0, 2'd0, 2'd0, 10, 1'b1, 1'b0, 1'b0);

    // Range boundary around 59
    put_field(12'h060);
    end_field(1'b0, 1'b0, 2'd0, 2'd0, 60, 1'b0, 1'b0, 1'b1);
    put_field(12'h059);
    end_field(1'b0, 1'b0, 2'd0, 2'd0, 59, 1'b0, 1'b0, 1'b0);

    // Abort a conversion of 123, then deliver 7
    put_field(12'h123);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
    idle(2);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    put_digit(2'd0, 4'h7);
    end_field(1'b0, 1'b0, 2'd0, 2'd0, 7, 1'b0, 1'b0, 1'b0);

    // field_start with field_end: start wins, stays collecting
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
    idle(1);
    check("start_end_busy", 32'(a_busy), 32'd1);
    idle(8);
    check("start_end_no_convert", 32'(a_busy), 32'd1);

    // Overwrite, then last bit together with field_end: units = 1001
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    put_bit(2'd0, 2'd2, 1'b1);
    put_bit(2'd0, 2'd2, 1'b0);
    put_bit(2'd0, 2'd0, 1'b1);
    end_field(1'b1, 1'b1, 2'd3, 2'd0, 9, 1'b0, 1'b0, 1'b0);

    // Write to digit 3 with three digits configured
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    put_bit(2'd3, 2'd0, 1'b1);
    put_digit(2'd0, 4'h5);
    end_field(1'b0, 1'b0, 2'd0, 2'd0, 5, 1'b1, 1'b0, 1'b0);

    // Unwritten field
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    end_field(1'b0, 1'b0, 2'd0, 2'd0, 0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 50 && sbq.size() != 0; i++) @(posedge clk);
    while (sbq.size() != 0) begin
      mon_e = sbq.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_valid: got no output expected value %0d", mon_e.value);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
